audio_sample_fetcher: RTL and testbench
=======================================

AUDIO_SAMPLE_FETCHER -- requirements
Module: audio_sample_fetcher

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_CHANNELS, 4, number of sample channels (1..8).
- DATA_WIDTH, 16, sample/memory word width.
- ADDR_WIDTH, 32, word address width.
- LEN_WIDTH, 24, sample-count width.
- FIFO_DEPTH, 8, per-channel FIFO entries (power of 2, >=2).
REQ-002 Clocking SHALL be one clock; reset SHALL be synchronous and active-high.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- chStart  in  NUM_CHANNELS  per-channel start pulse.
- chStop  in  NUM_CHANNELS  per-channel stop pulse.
- chBase  in  NUM_CHANNELS*ADDR_WIDTH  per-channel sample base word address.
- chLength  in  NUM_CHANNELS*LEN_WIDTH  per-channel length in samples.
- chLoop  in  NUM_CHANNELS  per-channel loop enable.
- chActive  out  NUM_CHANNELS  channel is still fetching.
- sampleOut  out  NUM_CHANNELS*DATA_WIDTH  FIFO head per channel.
- sampleValid  out  NUM_CHANNELS  FIFO non-empty.
- sampleReady  in  NUM_CHANNELS  consumer pops head.
- address  out  ADDR_WIDTH  memory word address.
- readEnable  out  1  memory read request.
- dataIn  in  DATA_WIDTH  memory read data.
- dataReady  in  1  read data valid this cycle.

Function
REQ-004 chStart[i] with chLength[i]!=0 SHALL latch base/length/loop, clear offset, flush FIFO i, discard any in-flight read for i, and set chActive[i] next cycle; with chLength[i]==0 it SHALL flush and leave chActive[i]=0.
REQ-005 chStop[i] SHALL clear chActive[i], flush FIFO i and discard any in-flight read for i; if chStart[i] and chStop[i] coincide, stop SHALL win.
REQ-006 Fetch FSM SHALL have states IDLE and READ.
REQ-007 In IDLE, grant SHALL go round-robin, starting after the last granted channel, to a channel with chActive=1 and FIFO count<FIFO_DEPTH; on grant, go to READ next cycle; no eligible channel keeps IDLE.
REQ-008 In READ, readEnable=1 and address=base+offset SHALL be held stable until dataReady=1; address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-009 On readEnable&&dataReady, dataIn SHALL be pushed into the granted FIFO (unless discarded), offset incremented, and FSM returns to IDLE; peak throughput is one sample per 2 cycles.
REQ-010 When offset+1==length on push: chLoop=1 SHALL reset offset to 0; chLoop=0 SHALL clear chActive (FIFO still drains).
REQ-011 FIFO: sampleValid[i]=count>0; pop on sampleValid&&sampleReady; simultaneous push and pop SHALL keep count; pop on empty and push on full SHALL be ignored (push on full cannot occur per REQ-007).
REQ-012 sampleOut[i] SHALL show the FIFO head combinationally, unchanged until popped.

Reset
REQ-013 rst SHALL force state IDLE, readEnable=0, address=0, chActive=0, sampleValid=0, sampleOut=0, FIFOs empty, round-robin pointer=0.
REQ-014 rst during READ SHALL drop readEnable next cycle; the pending response SHALL be discarded.

Structure
REQ-015 Package audio_pkg SHALL hold the fetch_state_t enum and default parameter constants.
REQ-016 Per-channel storage SHALL be sub-module sample_fifo (parameters DATA_WIDTH, FIFO_DEPTH; flush input), instantiated by generate.

Verification
REQ-017 dataReady=1, ch0 start base=0x100 len=3 loop=0, sampleReady=0 -> reads 0x100,0x101,0x102; FIFO0 count 3; chActive[0] low after third push.
REQ-018 ch0 base=0x200 len=2 loop=1, sampleReady=1 -> addresses cycle 0x200,0x201,0x200,... indefinitely.
REQ-019 ch0 and ch2 active, FIFO_DEPTH=8, no pops -> grants alternate 0,2,0,2; each stops at exactly 8 entries; readEnable then stays 0.
REQ-020 dataReady held 0 for 5 cycles in READ -> address and readEnable stable all 5 cycles; one push on dataReady.
REQ-021 chStop[1] while READ for ch1 -> response discarded, FIFO1 empty, chActive[1]=0; simultaneous chStart/chStop -> channel inactive.
REQ-022 rst asserted mid-READ -> readEnable=0 next cycle; all outputs at REQ-013 values.

Source files
------------

// File: rtl/audio_pkg.sv
// ============================================================================
// audio_pkg : shared types and default sizing for the audio sample fetcher
// Revision  : 1.0
// ============================================================================
`default_nettype none

package audio_pkg;

    localparam int C_NUM_CHANNELS = 4;
    localparam int C_DATA_WIDTH   = 16;
    localparam int C_ADDR_WIDTH   = 32;
    localparam int C_LEN_WIDTH    = 24;
    localparam int C_FIFO_DEPTH   = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// ============================================================================
// sample_fifo : per-channel sample FIFO with flush and combinational head
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sample_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  valid,
    output logic                  full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic                  w_push;
    logic                  w_pop;

    assign valid  = (r_count != '0);
    assign full   = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_push = push & ~full & ~flush;
    assign w_pop  = pop & valid & ~flush;
    // Empty FIFO presents zero so the head is well defined out of reset
    assign head   = valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/audio_sample_fetcher.sv
// ============================================================================
// audio_sample_fetcher : round-robin multi-channel sample fetch into FIFOs
// Revision             : 1.0
// ============================================================================
`default_nettype none

module audio_sample_fetcher
    import audio_pkg::*;
#(
    parameter int NUM_CHANNELS = C_NUM_CHANNELS,
    parameter int DATA_WIDTH   = C_DATA_WIDTH,
    parameter int ADDR_WIDTH   = C_ADDR_WIDTH,
    parameter int LEN_WIDTH    = C_LEN_WIDTH,
    parameter int FIFO_DEPTH   = C_FIFO_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CHANNELS-1:0]            chStart,
    input  logic [NUM_CHANNELS-1:0]            chStop,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] chBase,
    input  logic [NUM_CHANNELS*LEN_WIDTH-1:0]  chLength,
    input  logic [NUM_CHANNELS-1:0]            chLoop,
    output logic [NUM_CHANNELS-1:0]            chActive,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] sampleOut,
    output logic [NUM_CHANNELS-1:0]            sampleValid,
    input  logic [NUM_CHANNELS-1:0]            sampleReady,
    output logic [ADDR_WIDTH-1:0]              address,
    output logic                               readEnable,
    input  logic [DATA_WIDTH-1:0]              dataIn,
    input  logic                               dataReady
);

    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [ADDR_WIDTH-1:0]   r_base   [NUM_CHANNELS];
    logic [LEN_WIDTH-1:0]    r_len    [NUM_CHANNELS];
    logic [LEN_WIDTH-1:0]    r_offset [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_loop;
    logic [NUM_CHANNELS-1:0] r_active;

    fetch_state_t            r_state;
    fetch_state_t            w_state_next;
    logic [CH_W-1:0]         r_grant;
    logic [CH_W-1:0]         r_rr_ptr;
    logic [CH_W-1:0]         w_pick;
    logic                    w_found;
    logic [ADDR_WIDTH-1:0]   r_address;
    logic                    r_discard;
    logic                    w_accept;
    logic                    w_drop;

    logic [NUM_CHANNELS-1:0] w_full;
    logic [NUM_CHANNELS-1:0] w_valid;
    logic [NUM_CHANNELS-1:0] w_push;
    logic [NUM_CHANNELS-1:0] w_eligible;

    assign w_accept = (r_state == ST_READ) && dataReady;
    // A start/stop landing on the granted channel invalidates the response in flight
    assign w_drop   = r_discard | chStart[r_grant] | chStop[r_grant];
    // Channels being (re)configured this cycle are not granted until next cycle
    assign w_eligible = r_active & ~w_full & ~chStart & ~chStop;

    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            if (!w_found && w_eligible[(int'(r_rr_ptr) + k) % NUM_CHANNELS]) begin
                w_found = 1'b1;
                w_pick  = CH_W'((int'(r_rr_ptr) + k) % NUM_CHANNELS);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_found)   w_state_next = ST_READ;
            ST_READ: if (dataReady) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_address <= '0;
            r_discard <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && w_found) begin
                r_grant   <= w_pick;
                r_rr_ptr  <= w_pick;
                r_address <= r_base[w_pick] + ADDR_WIDTH'(r_offset[w_pick]);
                r_discard <= 1'b0;
            end else if (r_state == ST_READ && (chStart[r_grant] || chStop[r_grant])) begin
                r_discard <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (rst) begin
                r_base[i]   <= '0;
                r_len[i]    <= '0;
                r_offset[i] <= '0;
                r_loop[i]   <= 1'b0;
                r_active[i] <= 1'b0;
            end else if (chStop[i]) begin
                r_active[i] <= 1'b0;
            end else if (chStart[i]) begin
                r_base[i]   <= chBase[i*ADDR_WIDTH +: ADDR_WIDTH];
                r_len[i]    <= chLength[i*LEN_WIDTH +: LEN_WIDTH];
                r_loop[i]   <= chLoop[i];
                r_offset[i] <= '0;
                r_active[i] <= (chLength[i*LEN_WIDTH +: LEN_WIDTH] != '0);
            end else if (w_push[i]) begin
                if ((r_offset[i] + 1'b1) == r_len[i]) begin
                    r_offset[i] <= '0;
                    if (!r_loop[i]) r_active[i] <= 1'b0;
                end else begin
                    r_offset[i] <= r_offset[i] + 1'b1;
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
            assign w_push[i] = w_accept && !w_drop && (r_grant == CH_W'(i));

            sample_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .flush     (chStart[i] | chStop[i]),
                .push      (w_push[i]),
                .push_data (dataIn),
                .pop       (sampleReady[i]),
                .head      (sampleOut[i*DATA_WIDTH +: DATA_WIDTH]),
                .valid     (w_valid[i]),
                .full      (w_full[i])
            );
        end
    endgenerate

    assign chActive    = r_active;
    assign sampleValid = w_valid;
    assign readEnable  = (r_state == ST_READ);
    assign address     = r_address;

endmodule

`default_nettype wire

// File: tb/tb_audio_sample_fetcher.sv
// ============================================================================
// tb_audio_sample_fetcher : directed self-checking bench for the fetcher
// Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_audio_sample_fetcher;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int LW = 24;
    localparam int FD = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    chStart, chStop, chLoop, chActive, sampleValid, sampleReady;
    logic [N*AW-1:0] chBase;
    logic [N*LW-1:0] chLength;
    logic [N*DW-1:0] sampleOut;
    logic [AW-1:0]   address;
    logic            readEnable;
    logic [DW-1:0]   dataIn;
    logic            dataReady;

    int tests  = 0;
    int failed = 0;
    logic [AW-1:0] q[$];

    always #5 clk = ~clk;

    // Memory model: word at address A holds A[15:0] + 0x1000
    assign dataIn = address[DW-1:0] + 16'h1000;

    audio_sample_fetcher #(
        .NUM_CHANNELS (N), .DATA_WIDTH (DW), .ADDR_WIDTH (AW),
        .LEN_WIDTH (LW), .FIFO_DEPTH (FD)
    ) dut (
        .clk (clk), .rst (rst), .chStart (chStart), .chStop (chStop),
        .chBase (chBase), .chLength (chLength), .chLoop (chLoop),
        .chActive (chActive), .sampleOut (sampleOut), .sampleValid (sampleValid),
        .sampleReady (sampleReady), .address (address), .readEnable (readEnable),
        .dataIn (dataIn), .dataReady (dataReady)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int ch, input logic [AW-1:0] base, input logic [LW-1:0] len,
                          input logic lp);
        chBase[ch*AW +: AW]   = base;
        chLength[ch*LW +: LW] = len;
        chLoop[ch]            = lp;
    endtask

    task automatic pulse(input logic [N-1:0] st, input logic [N-1:0] sp);
        chStart = st;
        chStop  = sp;
        @(negedge clk);
        chStart = '0;
        chStop  = '0;
    endtask

    task automatic wait_re(input int budget);
        int n = 0;
        while (!readEnable && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("re_seen", readEnable, 1);
    endtask

    // Record accepted read addresses; stops on the negedge of the last one
    task automatic collect(input int n, input int budget);
        q.delete();
        for (int c = 0; c < budget && q.size() < n; c++) begin
            if (readEnable && dataReady) q.push_back(address);
            if (q.size() < n) @(negedge clk);
        end
        chk("collect_count", q.size(), n);
    endtask

    function automatic logic [AW-1:0] q_at(input int i);
        return (i < q.size()) ? q[i] : '1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        rst = 1'b1; chStart = '0; chStop = '0; chBase = '0; chLength = '0;
        chLoop = '0; sampleReady = '0; dataReady = 1'b1;
        step(2);
        chk("rst_active", chActive, 0);
        chk("rst_re", readEnable, 0);
        chk("rst_addr", address, 0);
        chk("rst_valid", sampleValid, 0);
        chk("rst_out", sampleOut, 0);
        rst = 1'b0;
        step(1);

        // One-shot channel 0, three samples, no consumer
        set_ch(0, 32'h100, 24'd3, 1'b0);
        pulse(4'b0001, 4'b0000);
        chk("t1_active", chActive[0], 1);
        collect(3, 20);
        for (int i = 0; i < 3; i++) chk("t1_addr", q_at(i), 32'h100 + i);
        step(2);
        chk("t1_done", chActive[0], 0);
        chk("t1_valid", sampleValid[0], 1);
        for (int k = 0; k < 3; k++) begin
            chk("t1_head", sampleOut[DW-1:0], 16'h1100 + k[15:0]);
            sampleReady[0] = 1'b1;
            @(negedge clk);
        end
        sampleReady[0] = 1'b0;
        chk("t1_drained", sampleValid[0], 0);

        // Looping channel 0, length 2, consumer always ready
        sampleReady = 4'b0001;
        set_ch(0, 32'h200, 24'd2, 1'b1);
        pulse(4'b0001, 4'b0000);
        collect(8, 40);
        for (int i = 0; i < 8; i++) chk("t2_addr", q_at(i), (i % 2 == 0) ? 32'h200 : 32'h201);
        pulse(4'b0000, 4'b0001);
        chk("t2_stop_active", chActive[0], 0);
        step(2);
        chk("t2_stop_re", readEnable, 0);
        chk("t2_stop_valid", sampleValid[0], 0);
        sampleReady = '0;

        // Channels 0 and 2 fill their FIFOs in alternation
        set_ch(0, 32'h300, 24'd100, 1'b0);
        set_ch(2, 32'h500, 24'd100, 1'b0);
        chStart = 4'b0001;
        @(negedge clk);
        chStart = 4'b0100;
        @(negedge clk);
        chStart = '0;
        collect(16, 80);
        for (int i = 0; i < 16; i++)
            chk("t3_addr", q_at(i), (i % 2 == 0) ? 32'h300 + i / 2 : 32'h500 + i / 2);
        step(2);
        ok = 1'b1;
        repeat (10) begin
            if (readEnable) ok = 1'b0;
            @(negedge clk);
        end
        chk("t3_re_low", ok, 1);
        chk("t3_valid", sampleValid, 4'b0101);
        chk("t3_active", chActive, 4'b0101);
        chk("t3_head0", sampleOut[0*DW +: DW], 16'h1300);
        chk("t3_head2", sampleOut[2*DW +: DW], 16'h1500);
        pulse(4'b0000, 4'b0101);
        chk("t3_flushed", sampleValid, 0);

        // Memory stalls for 5 cycles mid-read
        dataReady = 1'b0;
        set_ch(1, 32'h700, 24'd4, 1'b0);
        pulse(4'b0010, 4'b0000);
        wait_re(10);
        ok = 1'b1;
        repeat (5) begin
            if (!(readEnable && address == 32'h700)) ok = 1'b0;
            @(negedge clk);
        end
        chk("t4_stable", ok, 1);
        chk("t4_no_push", sampleValid[1], 0);
        dataReady = 1'b1;
        @(negedge clk);
        dataReady = 1'b0;
        chk("t4_push", sampleValid[1], 1);
        chk("t4_head", sampleOut[1*DW +: DW], 16'h1700);

        // Stop channel 1 while its second read is outstanding
        wait_re(10);
        chk("t5_addr", address, 32'h701);
        pulse(4'b0000, 4'b0010);
        chk("t5_active", chActive[1], 0);
        chk("t5_flushed", sampleValid[1], 0);
        chk("t5_still_read", readEnable, 1);
        dataReady = 1'b1;
        @(negedge clk);
        chk("t5_idle", readEnable, 0);
        chk("t5_discarded", sampleValid[1], 0);
        step(3);
        chk("t5_quiet", readEnable, 0);

        // Coincident start/stop, then zero-length start
        set_ch(3, 32'hA00, 24'd4, 1'b0);
        pulse(4'b1000, 4'b1000);
        chk("t5_startstop", chActive[3], 0);
        step(2);
        chk("t5_startstop_re", readEnable, 0);
        set_ch(3, 32'hB00, 24'd0, 1'b0);
        pulse(4'b1000, 4'b0000);
        chk("t5_zero_len", chActive[3], 0);
        step(2);
        chk("t5_zero_len_re", readEnable, 0);

        // Reset in the middle of a read
        dataReady = 1'b0;
        set_ch(0, 32'h900, 24'd4, 1'b0);
        pulse(4'b0001, 4'b0000);
        wait_re(10);
        chk("t6_addr", address, 32'h900);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_re", readEnable, 0);
        chk("t6_addr_rst", address, 0);
        chk("t6_active", chActive, 0);
        chk("t6_valid", sampleValid, 0);
        chk("t6_out", sampleOut, 0);
        rst = 1'b0;
        dataReady = 1'b1;
        step(3);
        chk("t6_quiet", readEnable, 0);
        chk("t6_no_push", sampleValid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
